// File: rtl/ulpi_phy_regfile_if.sv
// ULPI control signals shared by the link (master) and the PHY model (slave).
// The 8-bit tristate data bus stays a plain inout net on the PHY.
interface ulpi_phy_regfile_if;
   logic stp;
   logic dir;
   logic nxt;

   modport master (output stp, input dir, input nxt);
   modport slave  (input stp, output dir, output nxt);
endinterface

// File: rtl/ulpi_phy_regfile.sv
// Behavioural ULPI PHY: register file with ID bytes, extended addressing, NXT delay,
// stp aborts and injected RX CMDs. Optional macro ULPI_SETCLR_EN adds set/clear aliases.
module ulpi_phy_regfile #(
   parameter int          NUM_REGS   = 32,
   parameter int          NXT_DELAY  = 0,
   parameter logic [15:0] VENDOR_ID  = 16'h0424,
   parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
   input  logic              ulpi_clk,
   input  logic              ulpi_reset_n,
   ulpi_phy_regfile_if.slave ulpi,
   inout  wire  [7:0]        ulpi_data,
   input  logic              rx_cmd_valid,
   input  logic [7:0]        rx_cmd,
   output logic              rx_cmd_ready,
   output logic              reg_wr_strobe,
   output logic [7:0]        reg_wr_addr,
   output logic [7:0]        reg_wr_data
);
   localparam int         IDX_W      = $clog2(NUM_REGS);
   localparam logic [8:0] REG_LIMIT  = 9'(NUM_REGS);
   localparam logic [2:0] DELAY_INIT = 3'(NXT_DELAY);

   typedef enum logic [3:0] {
      IDLE, CMD_WAIT, EXT_ADDR, WR_DATA, WR_STP,
      RD_TA, RD_DATA, RD_TA2, RX_TA, RX_DATA, RX_TA2
   } state_t;

   state_t     state_reg;
   logic [2:0] delay_cnt_reg;
   logic       is_wr_reg;
   logic       is_ext_reg;
   logic [7:0] addr_reg;
   logic [7:0] wdata_reg;
   logic [7:0] dout_reg;
   logic       dout_en_reg;
   logic       dir_reg;
   logic       nxt_reg;
   logic [7:0] regs_reg [NUM_REGS];

   logic [7:0] tgt_addr;
   logic [1:0] op;
   logic       in_range;
   logic [7:0] cur_val;
   logic [7:0] new_val;
   logic [7:0] commit_val;
   logic       wr_en;

   assign ulpi_data = dout_en_reg ? dout_reg : 8'hzz;
   assign ulpi.dir  = dir_reg;
   assign ulpi.nxt  = nxt_reg;

   always_comb begin
      tgt_addr = addr_reg;
      op       = 2'd0;
`ifdef ULPI_SETCLR_EN
      // Each triple of addresses from 0x04 aliases one register: write, set, clear.
      if (addr_reg >= 8'h04 && addr_reg <= 8'h3E) begin
         op       = 2'((addr_reg - 8'h04) % 8'd3);
         tgt_addr = 8'h04 + 8'd3 * ((addr_reg - 8'h04) / 8'd3);
      end
`endif
   end

   assign in_range = (tgt_addr >= 8'h04) && ({1'b0, tgt_addr} < REG_LIMIT);

   always_comb begin
      cur_val = 8'h00;
      case (tgt_addr)
         8'h00:   cur_val = VENDOR_ID[7:0];
         8'h01:   cur_val = VENDOR_ID[15:8];
         8'h02:   cur_val = PRODUCT_ID[7:0];
         8'h03:   cur_val = PRODUCT_ID[15:8];
         default: if (in_range) cur_val = regs_reg[tgt_addr[IDX_W-1:0]];
      endcase
   end

   always_comb begin
      case (op)
         2'd1:    new_val = cur_val | wdata_reg;
         2'd2:    new_val = cur_val & ~wdata_reg;
         default: new_val = wdata_reg;
      endcase
   end

   // Dropped writes still report what the addressed location really holds.
   assign commit_val = in_range ? new_val : cur_val;
   assign wr_en      = (state_reg == WR_STP) && ulpi.stp && in_range;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge ulpi_clk or negedge ulpi_reset_n) begin
         if (!ulpi_reset_n)
            regs_reg[gi] <= 8'h00;
         else if (wr_en && tgt_addr == 8'(gi))
            regs_reg[gi] <= new_val;
      end
   end

   always_ff @(posedge ulpi_clk or negedge ulpi_reset_n) begin
      if (!ulpi_reset_n) begin
         state_reg     <= IDLE;
         delay_cnt_reg <= 3'd0;
         is_wr_reg     <= 1'b0;
         is_ext_reg    <= 1'b0;
         addr_reg      <= 8'h00;
         wdata_reg     <= 8'h00;
         dout_reg      <= 8'h00;
         dout_en_reg   <= 1'b0;
         dir_reg       <= 1'b0;
         nxt_reg       <= 1'b0;
         rx_cmd_ready  <= 1'b0;
         reg_wr_strobe <= 1'b0;
         reg_wr_addr   <= 8'h00;
         reg_wr_data   <= 8'h00;
      end else begin
         rx_cmd_ready  <= 1'b0;
         reg_wr_strobe <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A pending RX CMD takes the bus; the link retries its TX CMD afterwards.
               if (rx_cmd_valid) begin
                  dir_reg   <= 1'b1;
                  state_reg <= RX_TA;
               end else if (ulpi_data[7]) begin
                  is_wr_reg     <= !ulpi_data[6];
                  is_ext_reg    <= (ulpi_data[5:0] == 6'h2F);
                  addr_reg      <= {2'b00, ulpi_data[5:0]};
                  delay_cnt_reg <= DELAY_INIT;
                  nxt_reg       <= (NXT_DELAY == 0);
                  state_reg     <= CMD_WAIT;
               end
            end
            CMD_WAIT: begin
               if (ulpi.stp) begin
                  nxt_reg   <= 1'b0;
                  state_reg <= IDLE;
               end else if (nxt_reg) begin
                  if (is_ext_reg) begin
                     state_reg <= EXT_ADDR;
                  end else if (is_wr_reg) begin
                     state_reg <= WR_DATA;
                  end else begin
                     nxt_reg   <= 1'b0;
                     dir_reg   <= 1'b1;
                     state_reg <= RD_TA;
                  end
               end else if (delay_cnt_reg < 3'd2) begin
                  nxt_reg       <= 1'b1;
                  delay_cnt_reg <= 3'd0;
               end else begin
                  delay_cnt_reg <= delay_cnt_reg - 3'd1;
               end
            end
            EXT_ADDR: begin
               if (ulpi.stp) begin
                  nxt_reg   <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  addr_reg <= ulpi_data;
                  if (is_wr_reg) begin
                     state_reg <= WR_DATA;
                  end else begin
                     nxt_reg   <= 1'b0;
                     dir_reg   <= 1'b1;
                     state_reg <= RD_TA;
                  end
               end
            end
            WR_DATA: begin
               nxt_reg <= 1'b0;
               if (ulpi.stp) begin
                  state_reg <= IDLE;
               end else begin
                  wdata_reg <= ulpi_data;
                  state_reg <= WR_STP;
               end
            end
            WR_STP: begin
               if (ulpi.stp) begin
                  reg_wr_strobe <= 1'b1;
                  reg_wr_addr   <= tgt_addr;
                  reg_wr_data   <= commit_val;
                  state_reg     <= IDLE;
               end
            end
            RD_TA: begin
               dout_reg    <= cur_val;
               dout_en_reg <= 1'b1;
               state_reg   <= RD_DATA;
            end
            RD_DATA: begin
               dout_en_reg <= 1'b0;
               dir_reg     <= 1'b0;
               state_reg   <= RD_TA2;
            end
            RX_TA: begin
               dout_reg     <= rx_cmd;
               dout_en_reg  <= 1'b1;
               rx_cmd_ready <= 1'b1;
               state_reg    <= RX_DATA;
            end
            RX_DATA: begin
               dout_en_reg <= 1'b0;
               dir_reg     <= 1'b0;
               state_reg   <= RX_TA2;
            end
            RD_TA2, RX_TA2: begin
               state_reg <= IDLE;
            end
            default: begin
               dout_en_reg <= 1'b0;
               dir_reg     <= 1'b0;
               nxt_reg     <= 1'b0;
               state_reg   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ulpi_phy_regfile.sv
// Directed bench for ulpi_phy_regfile: one PHY with NXT_DELAY=0 and one with NXT_DELAY=3,
// driven by a simple link model; sel chooses which PHY the link talks to.
module tb_ulpi_phy_regfile;
   logic       ulpi_clk     = 1'b0;
   logic       ulpi_reset_n = 1'b0;
   logic       sel          = 1'b0;
   logic       link_oe      = 1'b0;
   logic [7:0] link_data    = 8'h00;
   logic       link_stp     = 1'b0;
   logic       link_rx_valid = 1'b0;
   logic [7:0] link_rx_cmd  = 8'h00;

   wire  [7:0] bus0_data;
   wire  [7:0] bus1_data;
   logic       rdy0, rdy1, stb0, stb1;
   logic [7:0] wa0, wa1, wd0, wd1;

   int tests_run    = 0;
   int tests_failed = 0;
   int overlap      = 0;

   ulpi_phy_regfile_if bus0_if ();
   ulpi_phy_regfile_if bus1_if ();

   assign bus0_if.stp = link_stp && !sel;
   assign bus1_if.stp = link_stp && sel;
   assign bus0_data   = (link_oe && !sel) ? link_data : 8'hzz;
   assign bus1_data   = (link_oe && sel)  ? link_data : 8'hzz;

   ulpi_phy_regfile #(.NUM_REGS(32), .NXT_DELAY(0)) dut0 (
      .ulpi_clk      (ulpi_clk),
      .ulpi_reset_n  (ulpi_reset_n),
      .ulpi          (bus0_if),
      .ulpi_data     (bus0_data),
      .rx_cmd_valid  (link_rx_valid && !sel),
      .rx_cmd        (link_rx_cmd),
      .rx_cmd_ready  (rdy0),
      .reg_wr_strobe (stb0),
      .reg_wr_addr   (wa0),
      .reg_wr_data   (wd0)
   );

   ulpi_phy_regfile #(.NUM_REGS(32), .NXT_DELAY(3)) dut3 (
      .ulpi_clk      (ulpi_clk),
      .ulpi_reset_n  (ulpi_reset_n),
      .ulpi          (bus1_if),
      .ulpi_data     (bus1_data),
      .rx_cmd_valid  (link_rx_valid && sel),
      .rx_cmd        (link_rx_cmd),
      .rx_cmd_ready  (rdy1),
      .reg_wr_strobe (stb1),
      .reg_wr_addr   (wa1),
      .reg_wr_data   (wd1)
   );

   wire       cur_dir  = sel ? bus1_if.dir : bus0_if.dir;
   wire       cur_nxt  = sel ? bus1_if.nxt : bus0_if.nxt;
   wire [7:0] cur_data = sel ? bus1_data : bus0_data;
   wire       cur_rdy  = sel ? rdy1 : rdy0;
   wire       cur_stb  = sel ? stb1 : stb0;
   wire [7:0] cur_wa   = sel ? wa1 : wa0;
   wire [7:0] cur_wd   = sel ? wd1 : wd0;

   always #8 ulpi_clk = ~ulpi_clk;

   always @(negedge ulpi_clk)
      if ((bus0_if.dir && bus0_if.nxt) || (bus1_if.dir && bus1_if.nxt)) overlap++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents a TX CMD and holds it until nxt is seen; returns cycles until nxt.
   task automatic tx_cmd(input logic [7:0] cmd, output int lat);
      lat       = 0;
      link_data = cmd;
      link_oe   = 1'b1;
      do begin
         @(posedge ulpi_clk); #1;
         lat++;
      end while (!cur_nxt && lat < 20);
      if (!cur_nxt) check("nxt_timeout", cur_nxt, 1'b1);
   endtask

   task automatic reg_write(input string tag, input logic [7:0] cmd, input logic [7:0] ext,
                            input logic [7:0] wdata, input logic [7:0] exp_addr,
                            input logic [7:0] exp_data);
      int lat;
      tx_cmd(cmd, lat);
      if (cmd[5:0] == 6'h2F) begin
         @(posedge ulpi_clk); #1;
         link_data = ext;
      end
      @(posedge ulpi_clk); #1;
      link_data = wdata;
      check({tag, "_nxt_data"}, cur_nxt, 1'b1);
      @(posedge ulpi_clk); #1;
      link_oe  = 1'b0;
      link_stp = 1'b1;
      check({tag, "_nxt_stp"}, cur_nxt, 1'b0);
      @(posedge ulpi_clk); #1;
      link_stp = 1'b0;
      check({tag, "_strobe"}, cur_stb, 1'b1);
      check({tag, "_addr"}, cur_wa, exp_addr);
      check({tag, "_data"}, cur_wd, exp_data);
      $display("[TB] write cmd=0x%02h data=0x%02h -> strobe addr=0x%02h data=0x%02h",
               cmd, wdata, cur_wa, cur_wd);
      @(posedge ulpi_clk); #1;
      check({tag, "_strobe_end"}, cur_stb, 1'b0);
   endtask

   task automatic reg_read(input string tag, input logic [7:0] cmd, input logic [7:0] ext,
                           input logic [7:0] exp);
      int lat;
      logic [7:0] got;
      tx_cmd(cmd, lat);
      if (cmd[5:0] == 6'h2F) begin
         @(posedge ulpi_clk); #1;
         link_data = ext;
      end
      @(posedge ulpi_clk); #1;
      link_oe = 1'b0;
      check({tag, "_dir_ta"}, cur_dir, 1'b1);
      @(posedge ulpi_clk); #1;
      got = cur_data;
      check({tag, "_dir_data"}, cur_dir, 1'b1);
      check({tag, "_value"}, got, exp);
      @(posedge ulpi_clk); #1;
      check({tag, "_dir_ta2"}, cur_dir, 1'b0);
      $display("[TB] read cmd=0x%02h ext=0x%02h -> 0x%02h", cmd, ext, got);
   endtask

   initial begin
      int lat;
      logic [7:0] e_addr5, e_data5, e_addr6, e_data6, e_rd4, e_rd6, e_t5_addr, e_t5_data;
`ifdef ULPI_SETCLR_EN
      e_addr5 = 8'h04; e_data5 = 8'hFF;
      e_addr6 = 8'h04; e_data6 = 8'hC3;
      e_rd4   = 8'hC3; e_rd6   = 8'hC3;
      e_t5_addr = 8'h04; e_t5_data = 8'h50;
`else
      e_addr5 = 8'h05; e_data5 = 8'h0F;
      e_addr6 = 8'h06; e_data6 = 8'h3C;
      e_rd4   = 8'hF0; e_rd6   = 8'h3C;
      e_t5_addr = 8'h06; e_t5_data = 8'h0A;
`endif

      repeat (3) @(posedge ulpi_clk);
      #1;
      check("rst_dir", cur_dir, 1'b0);
      check("rst_nxt", cur_nxt, 1'b0);
      check("rst_ready", cur_rdy, 1'b0);
      check("rst_strobe", cur_stb, 1'b0);
      check("rst_wr_addr", cur_wa, 8'h00);
      check("rst_wr_data", cur_wd, 8'h00);
      ulpi_reset_n = 1'b1;
      @(posedge ulpi_clk); #1;

      // Plain write/read with immediate nxt.
      tx_cmd(8'h84, lat);
      check("t1_nxt_latency", lat, 1);
      link_oe = 1'b0;
      @(posedge ulpi_clk); #1;
      link_oe   = 1'b1;
      link_data = 8'h5A;
      check("t1_nxt_data", cur_nxt, 1'b1);
      @(posedge ulpi_clk); #1;
      link_oe  = 1'b0;
      link_stp = 1'b1;
      check("t1_nxt_stp", cur_nxt, 1'b0);
      @(posedge ulpi_clk); #1;
      link_stp = 1'b0;
      check("t1_strobe", cur_stb, 1'b1);
      check("t1_addr", cur_wa, 8'h04);
      check("t1_data", cur_wd, 8'h5A);
      $display("[TB] write cmd=0x84 data=0x5A -> strobe addr=0x%02h data=0x%02h", cur_wa, cur_wd);
      @(posedge ulpi_clk); #1;
      reg_read("t1_rd04", 8'hC4, 8'h00, 8'h5A);

      // ID registers are read-only.
      reg_read("t2_rd00", 8'hC0, 8'h00, 8'h24);
      reg_read("t2_rd01", 8'hC1, 8'h00, 8'h04);
      reg_read("t2_rd02", 8'hC2, 8'h00, 8'h09);
      reg_read("t2_rd03", 8'hC3, 8'h00, 8'h00);
      reg_write("t2_wr01", 8'h81, 8'h00, 8'hFF, 8'h01, 8'h04);
      reg_read("t2_rd01b", 8'hC1, 8'h00, 8'h04);

      // Extended addressing, including the last implemented and an out-of-range address.
      reg_write("t3_wr1f", 8'hAF, 8'h1F, 8'h33, 8'h1F, 8'h33);
      reg_read("t3_rd1f", 8'hEF, 8'h1F, 8'h33);
      reg_write("t3_wr40", 8'hAF, 8'h40, 8'h11, 8'h40, 8'h00);
      reg_read("t3_rd40", 8'hEF, 8'h40, 8'h00);

      // NXT_DELAY=3 instance: latency and stp abort during WR_DATA.
      sel = 1'b1;
      tx_cmd(8'h85, lat);
      check("t4_nxt_latency", lat, 4);
      link_oe = 1'b0;
      @(posedge ulpi_clk); #1;
      link_oe   = 1'b1;
      link_data = 8'h77;
      link_stp  = 1'b1;
      @(posedge ulpi_clk); #1;
      link_stp = 1'b0;
      link_oe  = 1'b0;
      check("t4_nxt_abort", cur_nxt, 1'b0);
      check("t4_strobe_abort", cur_stb, 1'b0);
      @(posedge ulpi_clk); #1;
      check("t4_strobe_after", cur_stb, 1'b0);
      $display("[TB] aborted write cmd=0x85 on delayed PHY");
      reg_read("t4_rd05", 8'hC5, 8'h00, 8'h00);
      sel = 1'b0;

      // RX CMD collides with a TX CMD; RX CMD wins.
      link_data     = 8'h86;
      link_oe       = 1'b1;
      link_rx_cmd   = 8'h4C;
      link_rx_valid = 1'b1;
      @(posedge ulpi_clk); #1;
      link_oe = 1'b0;
      check("t5_dir_ta", cur_dir, 1'b1);
      check("t5_nxt_ta", cur_nxt, 1'b0);
      @(posedge ulpi_clk); #1;
      check("t5_dir_data", cur_dir, 1'b1);
      check("t5_rx_data", cur_data, 8'h4C);
      check("t5_ready", cur_rdy, 1'b1);
      check("t5_nxt_data", cur_nxt, 1'b0);
      link_rx_valid = 1'b0;
      @(posedge ulpi_clk); #1;
      check("t5_dir_ta2", cur_dir, 1'b0);
      check("t5_ready_end", cur_rdy, 1'b0);
      $display("[TB] rx cmd 0x4C delivered ahead of TX CMD 0x86");
      reg_write("t5_retry", 8'h86, 8'h00, 8'h0A, e_t5_addr, e_t5_data);

      // Write/set/clear aliases (plain registers when the option is off), then reset mid-read.
      reg_write("t6_wr84", 8'h84, 8'h00, 8'hF0, 8'h04, 8'hF0);
      reg_write("t6_wr85", 8'h85, 8'h00, 8'h0F, e_addr5, e_data5);
      reg_write("t6_wr86", 8'h86, 8'h00, 8'h3C, e_addr6, e_data6);
      reg_read("t6_rd04", 8'hC4, 8'h00, e_rd4);
      reg_read("t6_rd06", 8'hC6, 8'h00, e_rd6);

      tx_cmd(8'hC4, lat);
      @(posedge ulpi_clk); #1;
      link_oe = 1'b0;
      check("t6_rst_pre_dir", cur_dir, 1'b1);
      @(posedge ulpi_clk); #2;
      ulpi_reset_n = 1'b0;
      #1;
      check("t6_rst_dir", cur_dir, 1'b0);
      check("t6_rst_nxt", cur_nxt, 1'b0);
      $display("[TB] reset asserted during read of 0x04");
      @(posedge ulpi_clk); #1;
      ulpi_reset_n = 1'b1;
      @(posedge ulpi_clk); #1;
      reg_read("t6_rd04_rst", 8'hC4, 8'h00, 8'h00);
      reg_read("t6_rd00_rst", 8'hC0, 8'h00, 8'h24);

      check("nxt_dir_overlap", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1);
   end
endmodule
